// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline stage with a two-entry skid buffer and a registered in_ready.
// Define PIPE_SKID_PERF_EN to add the stall and transfer performance counters.
module pipe_skid_reg #(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
`ifdef PIPE_SKID_PERF_EN
   output logic [31:0]       perf_stall_cnt,
   output logic [31:0]       perf_xfer_cnt,
`endif
   output logic [1:0]        out_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_out_valid;
   logic              r_in_ready;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;

   logic w_push;
   logic w_pop;

   assign w_push = in_valid & r_in_ready;
   assign w_pop  = r_out_valid & out_ready;

   // r_state is the FSM state; out_valid/in_ready are flops updated with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_main      <= RST_DATA;
         r_skid      <= RST_DATA;
      end else if (flush) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_main      <= RST_DATA;
         r_skid      <= RST_DATA;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  r_main      <= in_data;
                  r_out_valid <= 1'b1;
                  r_state     <= HALF;
               end
            end
            HALF: begin
               if (w_push && w_pop) begin
                  r_main <= in_data;
               end else if (w_push) begin
                  r_skid     <= in_data;
                  r_in_ready <= 1'b0;
                  r_state    <= FULL;
               end else if (w_pop) begin
                  // head data is left in place; only the valid bit drops
                  r_out_valid <= 1'b0;
                  r_state     <= EMPTY;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_main     <= r_skid;
                  r_in_ready <= 1'b1;
                  r_state    <= HALF;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_main;
   assign out_count = r_state;

`ifdef PIPE_SKID_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_xfer_cnt;

   // saturating; flush intentionally leaves the counts alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
         r_xfer_cnt  <= '0;
      end else begin
         if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_pop && (r_xfer_cnt != 32'hFFFF_FFFF))
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall_cnt;
   assign perf_xfer_cnt  = r_xfer_cnt;
`endif

   a_count_legal : assert property (@(posedge clk) disable iff (!rst_n) out_count != 2'd3);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed self-checking bench for pipe_skid_reg (32-bit payload, RST_DATA = 0).
// Perf counter checks are included when PIPE_SKID_PERF_EN is defined.
module tb_pipe_skid_reg;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [1:0]  out_count;
`ifdef PIPE_SKID_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_xfer_cnt;
`endif

   int tests = 0;
   int fails = 0;

   pipe_skid_reg #(.DATA_W(32), .RST_DATA(32'h0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
`ifdef PIPE_SKID_PERF_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_xfer_cnt  (perf_xfer_cnt),
`endif
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one rising edge, then settle at the falling edge for checks/drive
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [1:0] c,
                            input logic rdy, input logic [31:0] d);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      chk({tag, ".count"}, {30'd0, out_count}, {30'd0, c});
      chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, rdy});
      chk({tag, ".data"},  out_data, d);
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk_state("reset", 1'b0, 2'd0, 1'b1, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // first word, one-cycle latency
      in_valid = 1'b1; in_data = 32'h1C00_0000; out_ready = 1'b1;
      step();
      chk_state("first", 1'b1, 2'd1, 1'b1, 32'h1C00_0000);

      // back-to-back stream, no bubbles
      for (int i = 0; i < 8; i++) begin
         in_data = 32'h10 + i;
         step();
         chk_state($sformatf("stream%0d", i), 1'b1, 2'd1, 1'b1, 32'h10 + i);
      end
      in_valid = 1'b0;
      step();
      chk_state("drain", 1'b0, 2'd0, 1'b1, 32'h17);

      // fill under backpressure
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
      step();
      chk_state("fillA", 1'b1, 2'd1, 1'b1, 32'hA);
      in_data = 32'hB;
      step();
      in_valid = 1'b0; in_data = 32'hDEAD;
      chk_state("full", 1'b1, 2'd2, 1'b0, 32'hA);
      for (int i = 0; i < 5; i++) begin
         step();
         chk_state($sformatf("hold%0d", i), 1'b1, 2'd2, 1'b0, 32'hA);
      end
      out_ready = 1'b1;
      step();
      chk_state("popA", 1'b1, 2'd1, 1'b1, 32'hB);
      step();
      chk_state("popB", 1'b0, 2'd0, 1'b1, 32'hB);

      // flush beats simultaneous push and pop
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
      step();
      in_data = 32'hB;
      step();
      chk_state("refill", 1'b1, 2'd2, 1'b0, 32'hA);
      flush = 1'b1; out_ready = 1'b1; in_data = 32'hC;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk_state("flush", 1'b0, 2'd0, 1'b1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_state($sformatf("postflush%0d", i), 1'b0, 2'd0, 1'b1, 32'h0);
      end

      // asynchronous reset while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
      step();
      in_data = 32'h78;
      step();
      in_valid = 1'b0;
      chk_state("prerst", 1'b1, 2'd2, 1'b0, 32'h77);
      #2 rst_n = 1'b0;
      #1 chk_state("asyncrst", 1'b0, 2'd0, 1'b1, 32'h0);
`ifdef PIPE_SKID_PERF_EN
      chk("perf.rst_stall", perf_stall_cnt, 32'd0);
      chk("perf.rst_xfer",  perf_xfer_cnt,  32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 0x55 is the first output; then 3 stalls and 4 pops
      in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
      step();
      chk_state("post_rst55", 1'b1, 2'd1, 1'b1, 32'h55);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_state($sformatf("stall%0d", i), 1'b1, 2'd1, 1'b1, 32'h55);
      end
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h60 + i;
         step();
         chk_state($sformatf("perfstream%0d", i), 1'b1, 2'd1, 1'b1, 32'h60 + i);
      end
      in_valid = 1'b0;
      step();
      chk_state("perfdrain", 1'b0, 2'd0, 1'b1, 32'h62);
`ifdef PIPE_SKID_PERF_EN
      chk("perf.stall", perf_stall_cnt, 32'd3);
      chk("perf.xfer",  perf_xfer_cnt,  32'd4);
`endif
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk_state("flush2", 1'b0, 2'd0, 1'b1, 32'h0);
`ifdef PIPE_SKID_PERF_EN
      chk("perf.flush_stall", perf_stall_cnt, 32'd3);
      chk("perf.flush_xfer",  perf_xfer_cnt,  32'd4);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
